// File: rtl/slc3_pkg.sv
// Shared types and helpers for the parametrised SLC-3 datapath.
// Optional build macro used by the top: SLC3_BUS_CONFLICT_EN.
package slc3_pkg;

  // Widest datapath the sign-extension helper supports.
  localparam int unsigned MaxWidth = 64;

  typedef enum logic [1:0] {
    AlukAdd  = 2'd0,
    AlukAnd  = 2'd1,
    AlukNot  = 2'd2,
    AlukPass = 2'd3
  } aluk_t;

  typedef enum logic [1:0] {
    PcmuxInc   = 2'd0,
    PcmuxBus   = 2'd1,
    PcmuxAdder = 2'd2,
    PcmuxHold  = 2'd3
  } pcmux_t;

  typedef enum logic [1:0] {
    Addr2Zero  = 2'd0,
    Addr2Off6  = 2'd1,
    Addr2Off9  = 2'd2,
    Addr2Off11 = 2'd3
  } addr2mux_t;

  // Sign-extend value[msb:0] to MaxWidth bits; callers keep the low WIDTH bits.
  function automatic logic [MaxWidth-1:0] sext(input logic [15:0] value, input int unsigned msb);
    logic [MaxWidth-1:0] shifted;
    int unsigned         sh;
    sh      = MaxWidth - 1 - msb;
    shifted = {{(MaxWidth-16){1'b0}}, value} << sh;
    return $signed(shifted) >>> sh;
  endfunction

endpackage

// File: rtl/slc3_reg_file.sv
// 8-entry general register file: two combinational read ports, one synchronous write port.
module slc3_reg_file
  import slc3_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ld_i,
  input  logic [2:0]       dr_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic [2:0]       sr1_i,
  input  logic [2:0]       sr2_i,
  output logic [WIDTH-1:0] sr1_o,
  output logic [WIDTH-1:0] sr2_o
);

  logic [WIDTH-1:0] regs_q [8];

  // Synchronous clear on Reset, otherwise write the selected register when loading.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
      end
    end else if (ld_i) begin
      regs_q[dr_i] <= din_i;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
  assign sr1_o = regs_q[sr1_i];
  assign sr2_o = regs_q[sr2_i];

endmodule

// File: rtl/slc3_datapath_param.sv
// SLC-3 datapath: PC, MAR, MDR, IR, register file, ALU, address adder, NZP/BEN and the
// shared CPU bus. WIDTH must be in 16..64; instruction fields always come from IR[15:0].
// Build macro SLC3_BUS_CONFLICT_EN adds a sticky Bus_Conflict output.
module slc3_datapath_param
  import slc3_pkg::*;
#(
  parameter int unsigned      WIDTH    = 16,
  parameter logic [WIDTH-1:0] PC_RESET = '0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LD_MAR,
  input  logic             LD_MDR,
  input  logic             LD_IR,
  input  logic             LD_BEN,
  input  logic             LD_CC,
  input  logic             LD_REG,
  input  logic             LD_PC,
  input  logic             GatePC,
  input  logic             GateMDR,
  input  logic             GateALU,
  input  logic             GateMARMUX,
  input  logic [1:0]       PCMUX,
  input  logic             DRMUX,
  input  logic             SR1MUX,
  input  logic             SR2MUX,
  input  logic             ADDR1MUX,
  input  logic [1:0]       ADDR2MUX,
  input  logic [1:0]       ALUK,
  input  logic             MIO_EN,
  input  logic [WIDTH-1:0] Data_from_SRAM,
  output logic [WIDTH-1:0] Bus,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] MAR,
  output logic [WIDTH-1:0] MDR,
  output logic [WIDTH-1:0] IR,
  output logic [2:0]       NZP,
  output logic             BEN
`ifdef SLC3_BUS_CONFLICT_EN
  ,
  output logic             Bus_Conflict
`endif
);

  logic [WIDTH-1:0] pc_q, mar_q, mdr_q, ir_q;
  logic [2:0]       nzp_q;
  logic             ben_q;

  logic [WIDTH-1:0] pc_d, mdr_d;
  logic [2:0]       nzp_d;
  logic [WIDTH-1:0] sr1_out, sr2_out, alu_b, alu_out;
  logic [WIDTH-1:0] addr1, addr2, adder_out;
  logic [2:0]       dr, sr1;

  logic [MaxWidth-1:0] off5_full, off6_full, off9_full, off11_full;
  logic [WIDTH-1:0]    off5, off6, off9, off11;

  assign off5_full  = sext(ir_q[15:0], 4);
  assign off6_full  = sext(ir_q[15:0], 5);
  assign off9_full  = sext(ir_q[15:0], 8);
  assign off11_full = sext(ir_q[15:0], 10);
  assign off5       = off5_full[WIDTH-1:0];
  assign off6       = off6_full[WIDTH-1:0];
  assign off9       = off9_full[WIDTH-1:0];
  assign off11      = off11_full[WIDTH-1:0];

  assign dr  = DRMUX ? 3'd7 : ir_q[11:9];
  assign sr1 = SR1MUX ? ir_q[8:6] : ir_q[11:9];

  slc3_reg_file #(
    .WIDTH (WIDTH)
  ) u_reg_file (
    .Clk   (Clk),
    .Reset (Reset),
    .ld_i  (LD_REG),
    .dr_i  (dr),
    .din_i (Bus),
    .sr1_i (sr1),
    .sr2_i (ir_q[2:0]),
    .sr1_o (sr1_out),
    .sr2_o (sr2_out)
  );

  // Address adder and ALU; both wrap modulo 2^WIDTH.
  always_comb begin
    addr1 = ADDR1MUX ? sr1_out : pc_q;
    unique case (addr2mux_t'(ADDR2MUX))
      Addr2Zero:  addr2 = '0;
      Addr2Off6:  addr2 = off6;
      Addr2Off9:  addr2 = off9;
      Addr2Off11: addr2 = off11;
      default:    addr2 = '0;
    endcase
    adder_out = addr1 + addr2;

    alu_b = SR2MUX ? off5 : sr2_out;
    unique case (aluk_t'(ALUK))
      AlukAdd:  alu_out = sr1_out + alu_b;
      AlukAnd:  alu_out = sr1_out & alu_b;
      AlukNot:  alu_out = ~sr1_out;
      AlukPass: alu_out = sr1_out;
      default:  alu_out = sr1_out;
    endcase
  end

  // Priority bus mux: GatePC > GateMDR > GateALU > GateMARMUX, idle bus reads zero.
  always_comb begin
    if (GatePC)          Bus = pc_q;
    else if (GateMDR)    Bus = mdr_q;
    else if (GateALU)    Bus = alu_out;
    else if (GateMARMUX) Bus = adder_out;
    else                 Bus = '0;
  end

  // Next-state values for PC, MDR and the condition codes.
  always_comb begin
    unique case (pcmux_t'(PCMUX))
      PcmuxInc:   pc_d = pc_q + WIDTH'(1);
      PcmuxBus:   pc_d = Bus;
      PcmuxAdder: pc_d = adder_out;
      PcmuxHold:  pc_d = pc_q;
      default:    pc_d = pc_q;
    endcase
    mdr_d = MIO_EN ? Data_from_SRAM : Bus;
    if (Bus[WIDTH-1])    nzp_d = 3'b100;
    else if (Bus == '0)  nzp_d = 3'b010;
    else                 nzp_d = 3'b001;
  end

  // Architectural registers; Reset overrides every load at the same edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q  <= PC_RESET;
      mar_q <= '0;
      mdr_q <= '0;
      ir_q  <= '0;
      nzp_q <= 3'b000;
      ben_q <= 1'b0;
    end else begin
      if (LD_PC)  pc_q  <= pc_d;
      if (LD_MAR) mar_q <= Bus;
      if (LD_MDR) mdr_q <= mdr_d;
      if (LD_IR)  ir_q  <= Bus;
      if (LD_CC)  nzp_q <= nzp_d;
      // Uses the pre-edge NZP even when LD_CC fires in the same cycle.
      if (LD_BEN) ben_q <= |(ir_q[11:9] & nzp_q);
    end
  end

  assign PC  = pc_q;
  assign MAR = mar_q;
  assign MDR = mdr_q;
  assign IR  = ir_q;
  assign NZP = nzp_q;
  assign BEN = ben_q;

`ifdef SLC3_BUS_CONFLICT_EN
  logic       conflict_q;
  logic [2:0] gate_cnt;

  assign gate_cnt = 3'(GatePC) + 3'(GateMDR) + 3'(GateALU) + 3'(GateMARMUX);

  // Sticky flag raised the cycle after more than one gate drives the bus.
  always_ff @(posedge Clk) begin
    if (Reset)              conflict_q <= 1'b0;
    else if (gate_cnt > 3'd1) conflict_q <= 1'b1;
  end

  assign Bus_Conflict = conflict_q;
`endif

endmodule

// File: tb/tb_slc3_datapath_param.sv
// Directed, table-driven bench for slc3_datapath_param at WIDTH=16.
module tb_slc3_datapath_param;

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic       drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux;
    logic [1:0] aluk;
    logic       mio_en;
  } ctrl_t;

  typedef enum {KBus, KPc, KMar, KMdr, KIr, KNzp, KBen} chk_e;

  typedef struct {
    string       name;
    ctrl_t       c;
    logic [15:0] sram;
    chk_e        k;
    logic [15:0] exp;
  } vec_t;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC;
  logic        GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0]  PCMUX, ADDR2MUX, ALUK;
  logic        DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN;
  logic [15:0] Data_from_SRAM, Bus, PC, MAR, MDR, IR;
  logic [2:0]  NZP;
  logic        BEN;
`ifdef SLC3_BUS_CONFLICT_EN
  logic        Bus_Conflict;
`endif

  int errors = 0;
  int checks = 0;
  vec_t vecs[$];

  always #5 Clk = ~Clk;

  slc3_datapath_param #(
    .WIDTH    (16),
    .PC_RESET (16'h0000)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .LD_MAR         (LD_MAR),
    .LD_MDR         (LD_MDR),
    .LD_IR          (LD_IR),
    .LD_BEN         (LD_BEN),
    .LD_CC          (LD_CC),
    .LD_REG         (LD_REG),
    .LD_PC          (LD_PC),
    .GatePC         (GatePC),
    .GateMDR        (GateMDR),
    .GateALU        (GateALU),
    .GateMARMUX     (GateMARMUX),
    .PCMUX          (PCMUX),
    .DRMUX          (DRMUX),
    .SR1MUX         (SR1MUX),
    .SR2MUX         (SR2MUX),
    .ADDR1MUX       (ADDR1MUX),
    .ADDR2MUX       (ADDR2MUX),
    .ALUK           (ALUK),
    .MIO_EN         (MIO_EN),
    .Data_from_SRAM (Data_from_SRAM),
    .Bus            (Bus),
    .PC             (PC),
    .MAR            (MAR),
    .MDR            (MDR),
    .IR             (IR),
    .NZP            (NZP),
    .BEN            (BEN)
`ifdef SLC3_BUS_CONFLICT_EN
    ,
    .Bus_Conflict   (Bus_Conflict)
`endif
  );

  task automatic drive(input ctrl_t c, input logic [15:0] s);
    LD_MAR = c.ld_mar;  LD_MDR = c.ld_mdr;  LD_IR = c.ld_ir;    LD_BEN = c.ld_ben;
    LD_CC = c.ld_cc;    LD_REG = c.ld_reg;  LD_PC = c.ld_pc;
    GatePC = c.gate_pc; GateMDR = c.gate_mdr; GateALU = c.gate_alu;
    GateMARMUX = c.gate_marmux;
    PCMUX = c.pcmux;    DRMUX = c.drmux;    SR1MUX = c.sr1mux;  SR2MUX = c.sr2mux;
    ADDR1MUX = c.addr1mux; ADDR2MUX = c.addr2mux; ALUK = c.aluk; MIO_EN = c.mio_en;
    Data_from_SRAM = s;
  endtask

  task automatic check(input string n, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  task automatic add(input string n, input ctrl_t c, input logic [15:0] s, input chk_e k,
                     input logic [15:0] e);
    vec_t v;
    v.name = n; v.c = c; v.sram = s; v.k = k; v.exp = e;
    vecs.push_back(v);
  endtask

  // MDR <= value from memory.
  task automatic add_mdr(input string n, input logic [15:0] s);
    add(n, ctrl_t'{mio_en: 1'b1, ld_mdr: 1'b1, default: '0}, s, KMdr, s);
  endtask

  // Bus is sampled before the edge, registers after it.
  task automatic apply(input vec_t v);
    logic [15:0] bus_pre;
    logic [15:0] got;
    @(negedge Clk);
    drive(v.c, v.sram);
    #1 bus_pre = Bus;
    @(posedge Clk);
    #1;
    unique case (v.k)
      KBus:    got = bus_pre;
      KPc:     got = PC;
      KMar:    got = MAR;
      KMdr:    got = MDR;
      KIr:     got = IR;
      KNzp:    got = {13'd0, NZP};
      default: got = {15'd0, BEN};
    endcase
    check(v.name, got, v.exp);
  endtask

  initial begin
    vec_t v;
    Reset = 1'b1;
    drive('0, 16'h0000);
    repeat (2) @(posedge Clk);
    #1;
    check("reset_pc", PC, 16'h0000);
    check("reset_mar", MAR, 16'h0000);
    check("reset_ir", IR, 16'h0000);
    check("reset_nzp", {13'd0, NZP}, 16'h0000);
    check("reset_ben", {15'd0, BEN}, 16'h0000);
    check("reset_bus_idle", Bus, 16'h0000);
`ifdef SLC3_BUS_CONFLICT_EN
    check("reset_conflict", {15'd0, Bus_Conflict}, 16'h0000);
`endif
    @(negedge Clk);
    Reset = 1'b0;

    add("pc_inc1", ctrl_t'{ld_pc: 1'b1, default: '0}, 16'h0, KPc, 16'h0001);
    add("pc_inc2", ctrl_t'{ld_pc: 1'b1, default: '0}, 16'h0, KPc, 16'h0002);
    add("pc_inc3", ctrl_t'{ld_pc: 1'b1, default: '0}, 16'h0, KPc, 16'h0003);
    add("bus_pc", ctrl_t'{gate_pc: 1'b1, default: '0}, 16'h0, KBus, 16'h0003);
    add("mar_pc", ctrl_t'{gate_pc: 1'b1, ld_mar: 1'b1, default: '0}, 16'h0, KMar, 16'h0003);
    add_mdr("mdr_sram", 16'h1283);
    add("ir_1283", ctrl_t'{gate_mdr: 1'b1, ld_ir: 1'b1, default: '0}, 16'h0, KIr, 16'h1283);
    add_mdr("mdr_5", 16'h0005);
    add("r1_w_cc_p", ctrl_t'{gate_mdr: 1'b1, ld_reg: 1'b1, ld_cc: 1'b1, default: '0}, 16'h0,
        KNzp, 16'h0001);
    add_mdr("mdr_0400", 16'h0400);
    add("ir_0400", ctrl_t'{gate_mdr: 1'b1, ld_ir: 1'b1, default: '0}, 16'h0, KIr, 16'h0400);
    add_mdr("mdr_fffa", 16'hFFFA);
    add("r2_w_no_cc", ctrl_t'{gate_mdr: 1'b1, ld_reg: 1'b1, default: '0}, 16'h0, KNzp, 16'h0001);
    add_mdr("mdr_1242", 16'h1242);
    add("ir_1242", ctrl_t'{gate_mdr: 1'b1, ld_ir: 1'b1, default: '0}, 16'h0, KIr, 16'h1242);
    add("alu_add_bus", ctrl_t'{gate_alu: 1'b1, sr1mux: 1'b1, default: '0}, 16'h0, KBus, 16'hFFFF);
    add("add_wr_cc_n", ctrl_t'{gate_alu: 1'b1, sr1mux: 1'b1, ld_reg: 1'b1, ld_cc: 1'b1,
        default: '0}, 16'h0, KNzp, 16'h0004);
    add("r1_pass", ctrl_t'{gate_alu: 1'b1, sr1mux: 1'b1, aluk: 2'd3, default: '0}, 16'h0, KBus,
        16'hFFFF);
    add("and_imm", ctrl_t'{gate_alu: 1'b1, sr1mux: 1'b1, aluk: 2'd1, sr2mux: 1'b1, default: '0},
        16'h0, KBus, 16'h0002);
    add("not_r1", ctrl_t'{gate_alu: 1'b1, aluk: 2'd2, default: '0}, 16'h0, KBus, 16'h0000);
    add("cc_zero", ctrl_t'{ld_cc: 1'b1, default: '0}, 16'h0, KNzp, 16'h0002);
    add_mdr("mdr_0a05", 16'h0A05);
    add("ir_0a05", ctrl_t'{gate_mdr: 1'b1, ld_ir: 1'b1, default: '0}, 16'h0, KIr, 16'h0A05);
    add("ben_z", ctrl_t'{ld_ben: 1'b1, default: '0}, 16'h0, KBen, 16'h0000);
    add("cc_pos", ctrl_t'{gate_mdr: 1'b1, ld_cc: 1'b1, default: '0}, 16'h0, KNzp, 16'h0001);
    add("ben_p", ctrl_t'{ld_ben: 1'b1, default: '0}, 16'h0, KBen, 16'h0001);
    add("ben_old_cc", ctrl_t'{ld_cc: 1'b1, ld_ben: 1'b1, default: '0}, 16'h0, KBen, 16'h0001);
    add("ben_new_cc", ctrl_t'{ld_ben: 1'b1, default: '0}, 16'h0, KBen, 16'h0000);
    add_mdr("mdr_3000", 16'h3000);
    add("pc_from_bus", ctrl_t'{gate_mdr: 1'b1, ld_pc: 1'b1, pcmux: 2'd1, default: '0}, 16'h0,
        KPc, 16'h3000);
    add_mdr("mdr_01fe", 16'h01FE);
    add("ir_01fe", ctrl_t'{gate_mdr: 1'b1, ld_ir: 1'b1, default: '0}, 16'h0, KIr, 16'h01FE);
    add("pc_off9_bus", ctrl_t'{gate_marmux: 1'b1, addr2mux: 2'd2, ld_pc: 1'b1, pcmux: 2'd1,
        default: '0}, 16'h0, KPc, 16'h2FFE);
    add("pc_adder_off6", ctrl_t'{ld_pc: 1'b1, pcmux: 2'd2, addr2mux: 2'd1, default: '0}, 16'h0,
        KPc, 16'h2FFC);
    add("pc_hold", ctrl_t'{ld_pc: 1'b1, pcmux: 2'd3, default: '0}, 16'h0, KPc, 16'h2FFC);
    add("marmux_off11", ctrl_t'{gate_marmux: 1'b1, addr2mux: 2'd3, default: '0}, 16'h0, KBus,
        16'h31FA);
    add("marmux_zero", ctrl_t'{gate_marmux: 1'b1, default: '0}, 16'h0, KBus, 16'h2FFC);
    add("prio_pc_mdr", ctrl_t'{gate_pc: 1'b1, gate_mdr: 1'b1, default: '0}, 16'h0, KBus,
        16'h2FFC);
    add("prio_mdr_alu", ctrl_t'{gate_mdr: 1'b1, gate_alu: 1'b1, gate_marmux: 1'b1,
        default: '0}, 16'h0, KBus, 16'h01FE);
    add("prio_alu_mux", ctrl_t'{gate_alu: 1'b1, gate_marmux: 1'b1, addr2mux: 2'd3, aluk: 2'd3,
        default: '0}, 16'h0, KBus, 16'h0000);
    add("ldpc_gatepc_mar", ctrl_t'{gate_pc: 1'b1, ld_pc: 1'b1, ld_mar: 1'b1, default: '0},
        16'h0, KMar, 16'h2FFC);
    add("ldpc_gatepc_next", ctrl_t'{gate_pc: 1'b1, default: '0}, 16'h0, KBus, 16'h2FFD);
    add("r7_before", ctrl_t'{gate_alu: 1'b1, aluk: 2'd3, sr1mux: 1'b1, default: '0}, 16'h0,
        KBus, 16'h0000);
    add_mdr("mdr_ffff", 16'hFFFF);
    add("r7_write", ctrl_t'{gate_mdr: 1'b1, ld_reg: 1'b1, drmux: 1'b1, default: '0}, 16'h0,
        KBus, 16'hFFFF);
    add("r7_read", ctrl_t'{gate_alu: 1'b1, aluk: 2'd3, sr1mux: 1'b1, default: '0}, 16'h0,
        KBus, 16'hFFFF);
    add("addr1_sr1", ctrl_t'{gate_marmux: 1'b1, addr1mux: 1'b1, sr1mux: 1'b1, addr2mux: 2'd1,
        default: '0}, 16'h0, KBus, 16'hFFFD);
    add("pc_ffff", ctrl_t'{gate_mdr: 1'b1, ld_pc: 1'b1, pcmux: 2'd1, default: '0}, 16'h0, KPc,
        16'hFFFF);
    add("pc_wrap", ctrl_t'{ld_pc: 1'b1, default: '0}, 16'h0, KPc, 16'h0000);
    add("pc_one", ctrl_t'{ld_pc: 1'b1, default: '0}, 16'h0, KPc, 16'h0001);
    add("mdr_from_bus", ctrl_t'{gate_pc: 1'b1, ld_mdr: 1'b1, default: '0}, 16'hABCD, KMdr,
        16'h0001);

    foreach (vecs[i]) begin
      v = vecs[i];
      apply(v);
    end

`ifdef SLC3_BUS_CONFLICT_EN
    @(negedge Clk);
    drive(ctrl_t'{gate_pc: 1'b1, gate_alu: 1'b1, default: '0}, 16'h0);
    #1 check("conflict_bus_pc", Bus, 16'h0001);
    @(posedge Clk);
    #1 check("conflict_flag", {15'd0, Bus_Conflict}, 16'h0001);
`endif

    // Reset in the middle of activity clears everything and ignores that edge's loads.
    @(negedge Clk);
    drive(ctrl_t'{gate_mdr: 1'b1, ld_pc: 1'b1, pcmux: 2'd1, ld_mar: 1'b1, ld_ir: 1'b1,
                  ld_cc: 1'b1, ld_ben: 1'b1, ld_reg: 1'b1, drmux: 1'b1, ld_mdr: 1'b1,
                  mio_en: 1'b1, default: '0}, 16'h8001);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    check("midrst_pc", PC, 16'h0000);
    check("midrst_mar", MAR, 16'h0000);
    check("midrst_mdr", MDR, 16'h0000);
    check("midrst_ir", IR, 16'h0000);
    check("midrst_nzp", {13'd0, NZP}, 16'h0000);
    check("midrst_ben", {15'd0, BEN}, 16'h0000);
`ifdef SLC3_BUS_CONFLICT_EN
    check("midrst_conflict", {15'd0, Bus_Conflict}, 16'h0000);
`endif
    @(negedge Clk);
    Reset = 1'b0;
    drive(ctrl_t'{gate_alu: 1'b1, aluk: 2'd3, sr1mux: 1'b1, default: '0}, 16'h0);
    #1 check("midrst_r7", Bus, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
